mem_port_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between the hart's instruction-fetch requester and data (load/store) requester.
- Accepts one request at a time, issues it downstream with a valid/ready handshake, and routes the read response back to the owner.
- Data requests win ties by default. A streak limit guarantees that fetch is never starved.
- Sits between the hart's imem/dmem request logic and the shared memory model or bus.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data requesters.
// Data wins ties, but a bounded streak of data grants forces a pending fetch through.
module mem_port_arbiter #(
    parameter int unsigned MAX_DSTREAK = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ireq_valid,
    input  logic [31:0] i_ireq_addr,
    output logic        o_ireq_ready,
    output logic        o_iresp_valid,
    output logic [31:0] o_iresp_rdata,
    input  logic        i_dreq_valid,
    input  logic [31:0] i_dreq_addr,
    input  logic        i_dreq_wen,
    input  logic [31:0] i_dreq_wdata,
    input  logic [3:0]  i_dreq_mask,
    output logic        o_dreq_ready,
    output logic        o_dresp_valid,
    output logic [31:0] o_dresp_rdata,
    output logic        o_mem_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_q, owner_d;  // 1 = data requester owns the transaction
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        iresp_valid_q, iresp_valid_d;
    logic [31:0] iresp_rdata_q, iresp_rdata_d;
    logic        dresp_valid_q, dresp_valid_d;
    logic [31:0] dresp_rdata_q, dresp_rdata_d;

    logic data_win;
    logic fetch_win;
    logic grant_data;
    logic grant_fetch;
    logic zero_store;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{i_ireq_addr[1:0], i_dreq_addr[1:0]};

    always_comb begin
        data_win    = i_dreq_valid && (!i_ireq_valid || (streak_q < MaxStreak));
        fetch_win   = i_ireq_valid && !data_win;
        grant_data  = (state_q == StIdle) && data_win;
        grant_fetch = (state_q == StIdle) && fetch_win;
        zero_store  = grant_data && i_dreq_wen && (i_dreq_mask == 4'b0000);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if ((grant_data && !zero_store) || grant_fetch) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (i_mem_ready) begin
                    state_d = wen_q ? StIdle : StResp;
                end
            end
            StResp: begin
                if (i_mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        streak_d      = streak_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        iresp_valid_d = 1'b0;
        iresp_rdata_d = iresp_rdata_q;
        dresp_valid_d = 1'b0;
        dresp_rdata_d = dresp_rdata_q;

        if (grant_data) begin
            if (!i_ireq_valid) begin
                streak_d = 4'd0;
            end else if (streak_q < MaxStreak) begin
                streak_d = streak_q + 4'd1;
            end
            owner_d = 1'b1;
            addr_d  = {i_dreq_addr[31:2], 2'b00};
            wen_d   = i_dreq_wen;
            wdata_d = i_dreq_wdata;
            mask_d  = i_dreq_mask;
            // Nothing to write: complete locally without touching the port.
            if (zero_store) begin
                dresp_valid_d = 1'b1;
                dresp_rdata_d = 32'd0;
            end
        end else if (grant_fetch) begin
            streak_d = 4'd0;
            owner_d  = 1'b0;
            addr_d   = {i_ireq_addr[31:2], 2'b00};
            wen_d    = 1'b0;
            wdata_d  = 32'd0;
            mask_d   = 4'b1111;
        end

        if ((state_q == StReq) && i_mem_ready && wen_q) begin
            dresp_valid_d = 1'b1;
            dresp_rdata_d = 32'd0;
        end

        if ((state_q == StResp) && i_mem_rvalid) begin
            if (owner_q) begin
                dresp_valid_d = 1'b1;
                dresp_rdata_d = i_mem_rdata;
            end else begin
                iresp_valid_d = 1'b1;
                iresp_rdata_d = i_mem_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            streak_q      <= 4'd0;
            owner_q       <= 1'b0;
            addr_q        <= 32'd0;
            wen_q         <= 1'b0;
            wdata_q       <= 32'd0;
            mask_q        <= 4'd0;
            iresp_valid_q <= 1'b0;
            iresp_rdata_q <= 32'd0;
            dresp_valid_q <= 1'b0;
            dresp_rdata_q <= 32'd0;
        end else begin
            streak_q      <= streak_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            wen_q         <= wen_d;
            wdata_q       <= wdata_d;
            mask_q        <= mask_d;
            iresp_valid_q <= iresp_valid_d;
            iresp_rdata_q <= iresp_rdata_d;
            dresp_valid_q <= dresp_valid_d;
            dresp_rdata_q <= dresp_rdata_d;
        end
    end

    // Readies are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        o_ireq_ready  = grant_fetch && i_rst_n;
        o_dreq_ready  = grant_data && i_rst_n;
        o_mem_valid   = (state_q == StReq);
        o_mem_addr    = addr_q;
        o_mem_wen     = wen_q;
        o_mem_wdata   = wdata_q;
        o_mem_mask    = mask_q;
        o_iresp_valid = iresp_valid_q;
        o_iresp_rdata = iresp_rdata_q;
        o_dresp_valid = dresp_valid_q;
        o_dresp_rdata = dresp_rdata_q;
        o_busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized phase scored against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int MaxD = 2;

    logic        clk;
    logic        rst_n;
    logic        ivalid;
    logic [31:0] iaddr;
    logic        iready;
    logic        iresp_v;
    logic [31:0] iresp_d;
    logic        dvalid;
    logic [31:0] daddr;
    logic        dwen;
    logic [31:0] dwdata;
    logic [3:0]  dmask;
    logic        dready;
    logic        dresp_v;
    logic [31:0] dresp_d;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ready_r;
    logic        rv_r;
    logic        stray_rv;
    logic [31:0] mem_rdata_r;
    logic        busy;
    wire         mem_rvalid = rv_r | stray_rv;

    int errors = 0;
    int checks = 0;

    // Downstream responder configuration (written by the main process only).
    bit          rnd_mode = 1'b0;
    int          cfg_rdy = 0;
    int          cfg_rv = 0;
    logic [31:0] cfg_data = 32'd0;

    mem_port_arbiter #(.MAX_DSTREAK(MaxD)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ireq_valid  (ivalid),
        .i_ireq_addr   (iaddr),
        .o_ireq_ready  (iready),
        .o_iresp_valid (iresp_v),
        .o_iresp_rdata (iresp_d),
        .i_dreq_valid  (dvalid),
        .i_dreq_addr   (daddr),
        .i_dreq_wen    (dwen),
        .i_dreq_wdata  (dwdata),
        .i_dreq_mask   (dmask),
        .o_dreq_ready  (dready),
        .o_dresp_valid (dresp_v),
        .o_dresp_rdata (dresp_d),
        .o_mem_valid   (mem_valid),
        .o_mem_addr    (mem_addr),
        .o_mem_wen     (mem_wen),
        .o_mem_wdata   (mem_wdata),
        .o_mem_mask    (mem_mask),
        .i_mem_ready   (mem_ready_r),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata_r),
        .o_busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Downstream memory: ready after a delay in REQ, read data after a delay in RESP.
    initial begin
        int rc, vc, rd, vd;
        logic [31:0] rdat;
        rc = 0; vc = 0; rd = 0; vd = 0; rdat = 32'd0;
        mem_ready_r = 1'b0; rv_r = 1'b0; mem_rdata_r = 32'd0;
        forever begin
            @(negedge clk);
            mem_ready_r = 1'b0;
            rv_r = 1'b0;
            if (!rst_n) begin
                rc = 0; vc = 0;
            end else begin
                if (mem_valid) begin
                    if (rc == 0) rd = rnd_mode ? int'($urandom_range(0, 3)) : cfg_rdy;
                    if (rc == rd) mem_ready_r = 1'b1;
                    rc++;
                end else rc = 0;
                if (busy && !mem_valid) begin
                    if (vc == 0) begin
                        vd = rnd_mode ? int'($urandom_range(0, 3)) : cfg_rv;
                        rdat = rnd_mode ? $urandom : cfg_data;
                    end
                    if (vc == vd) begin
                        rv_r = 1'b1;
                        mem_rdata_r = rdat;
                    end
                    vc++;
                end else vc = 0;
            end
        end
    end

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        bit          wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          rdy;
        int          rvd;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        bit          exp_mem;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic do_reset();
        rst_n = 1'b0;
        ivalid = 1'b0; iaddr = 32'd0;
        dvalid = 1'b0; daddr = 32'd0; dwen = 1'b0; dwdata = 32'd0; dmask = 4'd0;
        stray_rv = 1'b0;
        rnd_mode = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset mem_valid", mem_valid, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset resp_valid", {iresp_v, dresp_v}, 0);
        check("reset rdata", iresp_d | dresp_d, 0);
        rst_n = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int lat, pulses, busy_n, memv_n, other_n;
        cfg_rdy = v.rdy; cfg_rv = v.rvd; cfg_data = v.rdata;
        @(negedge clk);
        if (v.is_data) begin
            dvalid = 1'b1; daddr = v.addr; dwen = v.wen; dwdata = v.wdata; dmask = v.mask;
        end else begin
            ivalid = 1'b1; iaddr = v.addr;
        end
        #1;
        check({nm, " own ready"}, v.is_data ? dready : iready, 1);
        check({nm, " other ready"}, v.is_data ? iready : dready, 0);
        lat = -1; pulses = 0; busy_n = 0; memv_n = 0; other_n = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Latched copies must be used: scramble the inputs after accept.
                ivalid = 1'b0; dvalid = 1'b0;
                iaddr = $urandom; daddr = $urandom; dwdata = $urandom;
                dmask = 4'($urandom); dwen = ~dwen;
            end
            if (busy) busy_n++;
            if (mem_valid) begin
                memv_n++;
                check({nm, " mem_addr"}, mem_addr, v.exp_addr);
                check({nm, " mem_mask"}, mem_mask, v.exp_mask);
                check({nm, " mem_wen"}, mem_wen, v.is_data ? v.wen : 1'b0);
                if (v.is_data) check({nm, " mem_wdata"}, mem_wdata, v.wdata);
            end
            if (v.is_data ? dresp_v : iresp_v) begin
                pulses++;
                lat = c;
                check({nm, " resp rdata"}, v.is_data ? dresp_d : iresp_d, v.exp_rdata);
            end
            if (v.is_data ? iresp_v : dresp_v) other_n++;
        end
        check({nm, " pulses"}, pulses, 1);
        check({nm, " latency"}, lat, v.exp_lat);
        check({nm, " mem_valid cycles"}, memv_n, v.exp_mem ? v.rdy + 1 : 0);
        check({nm, " busy cycles"}, busy_n, v.exp_mem ? v.exp_lat - 1 : 0);
        check({nm, " other resp pulses"}, other_n, 0);
    endtask

    initial begin
        int dc, ic, ipc, n, seen, pulses_after, busy_after;
        int g[6];
        int exp_g[6];
        // Reference-model state for the randomized phase.
        int          streak_m;
        bit          inflight, mem_acc, cur_data, cur_wen, exp_ip, exp_dp, acc_i, acc_d;
        bit          er_i, er_d;
        logic [31:0] cur_addr, cur_wdata, last_i, last_d;
        logic [3:0]  cur_mask;

        vecs[0] = '{0, 32'h0000_0106, 0, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF,
                    32'h0000_0104, 4'hF, 1, 3, 32'hDEAD_BEEF};
        vecs[1] = '{1, 32'h0000_1001, 0, 32'h55AA_55AA, 4'h3, 2, 1, 32'h1234_5678,
                    32'h0000_1000, 4'h3, 1, 6, 32'h1234_5678};
        vecs[2] = '{1, 32'h0000_2003, 1, 32'hAB00_0000, 4'h8, 4, 0, 32'h0BAD_BAD0,
                    32'h0000_2000, 4'h8, 1, 6, 32'h0};
        vecs[3] = '{1, 32'h0000_3000, 1, 32'h1122_3344, 4'h0, 0, 0, 32'hFFFF_FFFF,
                    32'h0000_3000, 4'h0, 0, 1, 32'h0};
        vecs[4] = '{0, 32'hFFFF_FFFF, 0, 32'h0, 4'h0, 1, 2, 32'hCAFE_F00D,
                    32'hFFFF_FFFC, 4'hF, 1, 6, 32'hCAFE_F00D};
        exp_g = '{1, 1, 0, 1, 1, 0};

        do_reset();
        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous fetch and load: data first, fetch in the IDLE cycle of the data pulse.
        do_reset();
        cfg_rdy = 0; cfg_rv = 0; cfg_data = 32'h0D0D_0D0D;
        @(negedge clk);
        ivalid = 1'b1; iaddr = 32'h80; dvalid = 1'b1; daddr = 32'h40; dwen = 1'b0; dmask = 4'hF;
        #1;
        check("sim dreq_ready", dready, 1);
        check("sim ireq_ready", iready, 0);
        dc = -1; ic = -1; ipc = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) dvalid = 1'b0;
            if (ic >= 0) ivalid = 1'b0;
            #1;
            if (dresp_v && dc < 0) dc = c;
            if (iready && ic < 0) ic = c;
            if (iresp_v && ipc < 0) ipc = c;
        end
        check("sim data pulse cycle", dc, 3);
        check("sim fetch grant cycle", ic, 3);
        check("sim fetch pulse cycle", ipc, 6);

        // Both requesters held continuously: fetch forced through every MaxD data grants.
        do_reset();
        cfg_rdy = 0; cfg_rv = 0; cfg_data = 32'h7777_0000;
        @(negedge clk);
        ivalid = 1'b1; iaddr = 32'h600; dvalid = 1'b1; daddr = 32'h500; dwen = 1'b0; dmask = 4'hF;
        n = 0;
        for (int i = 0; i < 6; i++) g[i] = 2;
        for (int c = 0; c < 80 && n < 6; c++) begin
            #1;
            if (dready) begin g[n] = 1; n++; end
            else if (iready) begin g[n] = 0; n++; end
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) check($sformatf("streak grant %0d", i), g[i], exp_g[i]);
        ivalid = 1'b0; dvalid = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset while a load waits in RESP.
        do_reset();
        run_txn(vecs[1], "pre-reset load");
        cfg_rdy = 0; cfg_rv = 5; cfg_data = 32'h5555_AAAA;
        @(negedge clk);
        dvalid = 1'b1; daddr = 32'h4004; dwen = 1'b0; dmask = 4'hF;
        #1;
        check("rst load ready", dready, 1);
        @(negedge clk);
        dvalid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (busy && !mem_valid) seen = 1;
        end
        check("rst reached RESP", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst busy", busy, 0);
        check("rst mem_valid", mem_valid, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_mask", mem_mask, 0);
        check("rst readies", {iready, dready}, 0);
        check("rst resp_valid", {iresp_v, dresp_v}, 0);
        check("rst dresp_rdata", dresp_d, 0);
        check("rst iresp_rdata", iresp_d, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray_rv = 1'b1;
        @(negedge clk);
        stray_rv = 1'b0;
        pulses_after = 0; busy_after = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (iresp_v || dresp_v) pulses_after++;
            if (busy) busy_after++;
        end
        check("rst stray rvalid pulses", pulses_after, 0);
        check("rst stray busy", busy_after, 0);
        run_txn(vecs[0], "post-reset fetch");

        // Randomized traffic against the transaction-level model.
        do_reset();
        rnd_mode = 1'b1;
        streak_m = 0; inflight = 0; mem_acc = 0; cur_data = 0; cur_wen = 0;
        cur_addr = 0; cur_wdata = 0; cur_mask = 0; last_i = 0; last_d = 0;
        exp_ip = 0; exp_dp = 0; acc_i = 0; acc_d = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            check("rnd iresp_valid", iresp_v, exp_ip);
            check("rnd dresp_valid", dresp_v, exp_dp);
            check("rnd iresp_rdata", iresp_d, last_i);
            check("rnd dresp_rdata", dresp_d, last_d);
            check("rnd busy", busy, inflight);
            check("rnd mem_valid", mem_valid, inflight && !mem_acc);
            if (inflight && !mem_acc && mem_valid) begin
                check("rnd mem_addr", mem_addr, cur_addr);
                check("rnd mem_wen", mem_wen, cur_wen);
                check("rnd mem_mask", mem_mask, cur_mask);
                if (cur_data) check("rnd mem_wdata", mem_wdata, cur_wdata);
            end
            exp_ip = 0; exp_dp = 0;
            if (acc_i) begin ivalid = 1'b0; acc_i = 0; end
            if (acc_d) begin dvalid = 1'b0; acc_d = 0; end
            if (!ivalid && $urandom_range(0, 2) == 0) begin
                ivalid = 1'b1; iaddr = $urandom;
            end
            if (!dvalid && $urandom_range(0, 2) == 0) begin
                dvalid = 1'b1; daddr = $urandom; dwen = 1'($urandom); dwdata = $urandom;
                dmask = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            end
            #1;
            er_d = !inflight && dvalid && (!ivalid || streak_m < MaxD);
            er_i = !inflight && ivalid && !er_d;
            check("rnd dreq_ready", dready, er_d);
            check("rnd ireq_ready", iready, er_i);
            if (inflight) begin
                if (!mem_acc) begin
                    if (mem_ready_r) begin
                        if (cur_wen) begin exp_dp = 1; last_d = 0; inflight = 0; end
                        else mem_acc = 1;
                    end
                end else if (mem_rvalid) begin
                    if (cur_data) begin exp_dp = 1; last_d = mem_rdata_r; end
                    else begin exp_ip = 1; last_i = mem_rdata_r; end
                    inflight = 0;
                end
            end else if (er_d) begin
                streak_m = ivalid ? ((streak_m < MaxD) ? streak_m + 1 : streak_m) : 0;
                if (dwen && dmask == 4'h0) begin
                    exp_dp = 1; last_d = 0;
                end else begin
                    inflight = 1; mem_acc = 0; cur_data = 1; cur_wen = dwen;
                    cur_addr = daddr & 32'hFFFF_FFFC; cur_wdata = dwdata; cur_mask = dmask;
                end
                acc_d = 1;
            end else if (er_i) begin
                streak_m = 0;
                inflight = 1; mem_acc = 0; cur_data = 0; cur_wen = 0;
                cur_addr = iaddr & 32'hFFFF_FFFC; cur_mask = 4'hF;
                acc_i = 1;
            end
        end
        ivalid = 1'b0; dvalid = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
